// File: rtl/nn_weight_loader.sv
// Framed byte-stream loader for the perceptron weight register file.
// Frames are SYNC, ADDR, W0..W7, BIAS, CHK and are checked by XOR and an idle timeout.
module nn_weight_loader #(
    parameter int              NUM_NEURONS = 8,
    parameter int              NUM_WEIGHTS = 8,
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_BYTE  = 8'hA5,
    parameter int              TIMEOUT     = 255
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          ena,
    input  logic                                          load_valid,
    input  logic [WIDTH-1:0]                              load_data,
    output logic                                          load_ready,
    output logic [NUM_NEURONS*(NUM_WEIGHTS+1)*WIDTH-1:0]  weights_flat,
    output logic [NUM_NEURONS-1:0]                        loaded_mask,
    output logic                                          all_loaded,
    output logic                                          frame_done,
    output logic                                          frame_err,
    output logic [7:0]                                    err_count
);

    localparam int SLOTS = NUM_WEIGHTS + 1;
    localparam int AW    = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam int IW    = $clog2(SLOTS + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_PAYLOAD,
        S_CHECK,
        S_COMMIT
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [AW-1:0]      r_row;
    logic               r_addr_bad;
    logic [IW-1:0]      r_idx;
    logic [WIDTH-1:0]   r_xor;
    logic [TW-1:0]      r_tmo;
    logic [WIDTH-1:0]   r_shadow [SLOTS];
    logic [WIDTH-1:0]   r_rows   [NUM_NEURONS][SLOTS];
    logic [NUM_NEURONS-1:0] r_mask;
    logic               r_done;
    logic               r_err;
    logic [7:0]         r_errcnt;

    logic w_ready;
    logic w_acc;
    logic w_in_frame;
    logic w_tmo_hit;
    logic w_chk_ok;
    logic w_fail;

    assign w_ready    = rst_n && (r_state != S_COMMIT);
    assign w_acc      = load_valid && w_ready && ena;
    assign w_in_frame = (r_state == S_ADDR) || (r_state == S_PAYLOAD) ||
                        (r_state == S_CHECK);
    assign w_tmo_hit  = w_in_frame && ena && !w_acc &&
                        (r_tmo == TW'(TIMEOUT - 1));
    assign w_chk_ok   = (load_data == r_xor) && !r_addr_bad;
    assign w_fail     = w_tmo_hit ||
                        ((r_state == S_CHECK) && w_acc && !w_chk_ok);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_acc && (load_data == SYNC_BYTE)) w_next = S_ADDR;
            end
            S_ADDR: begin
                if (w_acc)          w_next = S_PAYLOAD;
                else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_PAYLOAD: begin
                if (w_acc && (r_idx == IW'(NUM_WEIGHTS))) w_next = S_CHECK;
                else if (w_tmo_hit)                      w_next = S_IDLE;
            end
            S_CHECK: begin
                if (w_acc)          w_next = w_chk_ok ? S_COMMIT : S_IDLE;
                else if (w_tmo_hit) w_next = S_IDLE;
            end
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row      <= '0;
            r_addr_bad <= 1'b0;
            r_idx      <= '0;
            r_xor      <= '0;
            r_tmo      <= '0;
            r_mask     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_errcnt   <= '0;
            for (int k = 0; k < SLOTS; k++) r_shadow[k] <= '0;
            for (int n = 0; n < NUM_NEURONS; n++)
                for (int k = 0; k < SLOTS; k++) r_rows[n][k] <= '0;
        end else begin
            r_done <= (r_state == S_COMMIT);
            r_err  <= w_fail;
            if (w_fail && (r_errcnt != 8'hFF)) r_errcnt <= r_errcnt + 8'd1;

            // Idle counter only runs while a frame is open and the block is enabled
            if (!w_in_frame || w_acc || w_tmo_hit) r_tmo <= '0;
            else if (ena)                          r_tmo <= r_tmo + TW'(1);

            if ((r_state == S_ADDR) && w_acc) begin
                r_row      <= load_data[AW-1:0];
                r_addr_bad <= (load_data >= WIDTH'(NUM_NEURONS));
                r_xor      <= load_data;
                r_idx      <= '0;
            end

            if ((r_state == S_PAYLOAD) && w_acc) begin
                r_shadow[r_idx] <= load_data;
                r_xor           <= r_xor ^ load_data;
                r_idx           <= r_idx + IW'(1);
            end

            if (r_state == S_COMMIT) begin
                for (int k = 0; k < SLOTS; k++) r_rows[r_row][k] <= r_shadow[k];
                r_mask[r_row] <= 1'b1;
            end
        end
    end

    for (genvar n = 0; n < NUM_NEURONS; n++) begin : g_row
        for (genvar k = 0; k < SLOTS; k++) begin : g_slot
            assign weights_flat[(n*SLOTS+k)*WIDTH +: WIDTH] = r_rows[n][k];
        end
    end

    assign load_ready  = w_ready;
    assign loaded_mask = r_mask;
    assign all_loaded  = &r_mask;
    assign frame_done  = r_done;
    assign frame_err   = r_err;
    assign err_count   = r_errcnt;

endmodule

// File: doc/nn_weight_loader.md
Name: nn_weight_loader

Overview:
- Writer side of the perceptron array's weight interface: receives framed weight bytes over a byte stream (valid/ready) and commits one neuron's 8 weights plus bias per frame into a register file.
- Register file drives a flat bus feeding the perceptron instances, replacing hard-wired weight constants.
- Frame integrity is enforced by an XOR checksum and an idle timeout; a row is only overwritten when its frame is valid.

Parameters:
- NUM_NEURONS, 8, number of weight rows (perceptrons).
- NUM_WEIGHTS, 8, weights per row (bias stored separately).
- WIDTH, 8, bits per weight/bias; must equal the byte width of load_data.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 255, maximum number of idle enabled cycles between accepted bytes inside a frame.

Ports:
- clk  in  1  clock; everything is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  block enable; when low, no byte is accepted and the timeout counter is frozen.
- load_valid  in  1  load_data is valid.
- load_data  in  8  stream byte.
- load_ready  out  1  loader can accept a byte.
- weights_flat  out  NUM_NEURONS*(NUM_WEIGHTS+1)*WIDTH  row n, slot k at bits [(n*(NUM_WEIGHTS+1)+k)*WIDTH +: WIDTH]; k=0..7 are weights, k=8 is bias.
- loaded_mask  out  NUM_NEURONS  bit n set once row n has been committed.
- all_loaded  out  1  AND of loaded_mask.
- frame_done  out  1  one-cycle pulse on a successful commit.
- frame_err  out  1  one-cycle pulse when a frame is rejected.
- err_count  out  8  count of rejected frames; saturates at 255.

Behaviour:
- Byte accepted: load_valid & load_ready & ena on a clock edge.
- Frame format: SYNC_BYTE, ADDR, W0..W7, BIAS, CHK.
  - CHK = XOR of ADDR, W0..W7 and BIAS.
- Reset (rst_n=0 on an edge): state IDLE, all weights 0, loaded_mask 0, frame_done 0, frame_err 0, err_count 0, timeout counter 0. A partial frame in progress is discarded.
- FSM states: IDLE, ADDR, PAYLOAD, CHECK, COMMIT.
  - IDLE: on an accepted SYNC_BYTE, go to ADDR. Any other byte is consumed and dropped.
  - ADDR: latch the address byte, clear the shadow index, seed the running XOR with ADDR, go to PAYLOAD.
    - If ADDR >= NUM_NEURONS, set a sticky addr_bad flag; the frame is still consumed to its end.
  - PAYLOAD: each accepted byte goes to shadow[idx] and is XORed into the running checksum; idx increments. After the 9th byte (idx=8), go to CHECK.
  - CHECK: on the accepted byte, if it equals the running XOR and addr_bad=0, go to COMMIT. Otherwise go to IDLE, pulse frame_err on the next cycle, and increment err_count.
  - COMMIT: lasts exactly one cycle with load_ready=0. On its edge, shadow is copied into row ADDR, loaded_mask[ADDR] is set, frame_done pulses the following cycle, and the state returns to IDLE.
- load_ready: 1 in every state except COMMIT; 0 during reset.
- Latency: checksum byte accepted at edge E. COMMIT spans E..E+1. weights_flat and loaded_mask reflect the new row and frame_done=1 in the cycle after edge E+1.
- A SYNC_BYTE value seen inside a frame is treated as ordinary data. There is no resync mid-frame.
- Timeout:
  - In ADDR, PAYLOAD and CHECK, the counter increments on every ena=1 cycle with no accepted byte.
  - It clears on every accepted byte and whenever the state is IDLE.
  - Reaching TIMEOUT forces IDLE, pulses frame_err and increments err_count; shadow data is discarded.
- Rows not addressed by a frame hold their values. A rejected frame never modifies any row or mask bit.
- Re-loading an already loaded row overwrites it; its mask bit stays 1.
- err_count saturates at 255 and does not wrap.
- frame_done and frame_err are never high in the same cycle.

Test Plan:
- Reset, then stream A5 03 01 02 03 04 05 06 07 08 00 0B with valid held high → row 3 slots = 01..08, bias 00; loaded_mask=0x08; frame_done is a single pulse 2 cycles after the CHK byte is accepted; load_ready=0 for exactly 1 cycle.
- Same frame with CHK=0C → frame_err pulse, err_count=1, row 3 = 0, loaded_mask=0x00.
- ADDR=09 with correct XOR CHK (= 09^01^...^08^00 = 0x01) → frame_err, no row changes, err_count increments.
- Send A5 03 01, then valid=0 for 255 enabled cycles → frame_err, state IDLE. Then hold ena=0 for 1000 cycles mid-frame → no timeout. A subsequent full valid frame commits correctly.
- Send 00 FF 3C before a valid frame to row 0, then frames for rows 1..7 → garbage bytes are dropped; all_loaded=1 only after the 8th commit; every row matches its sent data.
- Assert rst_n=0 for one cycle after the 6th payload byte of a row-5 frame → all weights 0, mask 0; a following complete frame to row 5 commits normally.
